// File: rtl/apb_sram_ctrl.sv
// apb_sram_ctrl: APB3 slave front-end for a single-port synchronous SRAM with one-cycle read latency
module apb_sram_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int APB_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic                      sram_wr_en,
  output logic [ADDR_WIDTH-1:0]     sram_addr,
  output logic [DATA_WIDTH-1:0]     sram_din,
  input  logic [DATA_WIDTH-1:0]     sram_dout
);
  typedef enum logic [2:0] {IDLE, WR, RD1, RD2, DONE} state_t;
  state_t                state_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  setup;
  logic                  in_range;
  assign setup    = psel && !penable;
  assign in_range = paddr[APB_ADDR_WIDTH-1:ADDR_WIDTH] == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      wr_en_q   <= 1'b0;
      case (state_q)
        IDLE: if (setup) begin
          if (!in_range) begin
            state_q   <= DONE;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
          end else if (pwrite) begin
            state_q <= WR;
            wr_en_q <= 1'b1;
            addr_q  <= paddr[ADDR_WIDTH-1:0];
            din_q   <= pwdata;
          end else begin
            state_q <= RD1;
            addr_q  <= paddr[ADDR_WIDTH-1:0];
          end
        end
        // a dropped psel still lets an already-registered write commit; only the pready pulse is suppressed
        WR: begin
          state_q  <= psel ? DONE : IDLE;
          pready_q <= psel;
        end
        RD1: state_q <= psel ? RD2 : IDLE;
        RD2: if (psel) begin
          state_q  <= DONE;
          pready_q <= 1'b1;
          prdata_q <= sram_dout;
        end else begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign prdata     = prdata_q;
  assign pready     = pready_q;
  assign pslverr    = pslverr_q;
  assign sram_wr_en = wr_en_q;
  assign sram_addr  = addr_q;
  assign sram_din   = din_q;
endmodule
